// File: rtl/id_stage.sv
// RV32I decode stage: decode, 32x32 register file with write-through bypass, load-use detection.
// Latency 1 cycle to the ID/EX register; stall_out is combinational.
// stall_in holds the ID/EX register; a load-use hazard loads a bubble and holds fetch.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        stall_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic        stall_out,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_rs1_data,
  output logic [31:0] id_rs2_data,
  output logic [31:0] id_imm,
  output logic [3:0]  id_alu_op,
  output logic [2:0]  id_funct3,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_branch,
  output logic        id_jump,
  output logic        id_alu_src,
  output logic        id_illegal
);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic        illegal;
  } id_t;

  logic [31:0] rf [32];
  id_t         dec, q;
  logic        rs1_used, rs2_used, load_use;
  logic [6:0]  opcode;

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Bubble keeps the payload fields but clears valid and every control bit.
  function automatic id_t kill(input id_t d);
    id_t k;
    k           = d;
    k.valid     = 1'b0;
    k.alu_op    = ALU_ADD;
    k.reg_write = 1'b0;
    k.mem_read  = 1'b0;
    k.mem_write = 1'b0;
    k.branch    = 1'b0;
    k.jump      = 1'b0;
    k.alu_src   = 1'b0;
    k.illegal   = 1'b0;
    return k;
  endfunction

  assign opcode = in_instr[6:0];

  always_comb begin
    dec          = '0;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    dec.valid    = 1'b1;
    dec.pc       = in_pc;
    dec.instr    = in_instr;
    dec.rs1      = in_instr[19:15];
    dec.rs2      = in_instr[24:20];
    dec.rd       = in_instr[11:7];
    dec.funct3   = in_instr[14:12];
    // x0 reads zero; a same-cycle writeback bypasses the array.
    dec.rs1_data = (dec.rs1 == 5'd0) ? 32'd0 :
                   (wb_en && wb_rd == dec.rs1) ? wb_data : rf[dec.rs1];
    dec.rs2_data = (dec.rs2 == 5'd0) ? 32'd0 :
                   (wb_en && wb_rd == dec.rs2) ? wb_data : rf[dec.rs2];
    case (opcode)
      OP_LUI: begin
        dec.imm = {in_instr[31:12], 12'b0}; dec.alu_op = ALU_PASSB;
        dec.reg_write = 1'b1; dec.alu_src = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = {in_instr[31:12], 12'b0}; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
      end
      OP_JAL: begin
        dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        dec.reg_write = 1'b1; dec.jump = 1'b1;
      end
      OP_JALR: begin
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; rs1_used = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        dec.alu_op = ALU_SUB; dec.branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_LOAD: begin
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1; rs1_used = 1'b1;
      end
      OP_STORE: begin
        dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.mem_write = 1'b1; dec.alu_src = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_IMM: begin
        dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        // Only shifts look at bit 30; ADDI with a negative immediate must stay ADD.
        dec.alu_op = arith_op(in_instr[14:12], (in_instr[14:12] == 3'b101) && in_instr[30]);
        dec.reg_write = 1'b1; dec.alu_src = 1'b1; rs1_used = 1'b1;
      end
      OP_OP: begin
        dec.alu_op = arith_op(in_instr[14:12], in_instr[30]);
        dec.reg_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  assign load_use = in_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((rs1_used && ex_rd == dec.rs1) || (rs2_used && ex_rd == dec.rs2));
  assign stall_out = load_use && !flush;

  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      q    <= '0;
      q.pc <= RESET_PC;
    end else if (flush) begin
      q <= kill(dec);
    end else if (!stall_in) begin
      q <= (in_valid && !load_use) ? dec : kill(dec);
    end
  end

  assign id_valid     = q.valid;
  assign id_pc        = q.pc;
  assign id_instr     = q.instr;
  assign id_rs1       = q.rs1;
  assign id_rs2       = q.rs2;
  assign id_rd        = q.rd;
  assign id_rs1_data  = q.rs1_data;
  assign id_rs2_data  = q.rs2_data;
  assign id_imm       = q.imm;
  assign id_alu_op    = q.alu_op;
  assign id_funct3    = q.funct3;
  assign id_reg_write = q.reg_write;
  assign id_mem_read  = q.mem_read;
  assign id_mem_write = q.mem_write;
  assign id_branch    = q.branch;
  assign id_jump      = q.jump;
  assign id_alu_src   = q.alu_src;
  assign id_illegal   = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expectations queued at drive time, popped and checked after each edge.
module tb_id_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_, in_valid, stall_in, flush, wb_en, ex_mem_read;
  logic [31:0] in_pc, in_instr, wb_data;
  logic [4:0]  wb_rd, ex_rd;
  logic        stall_out, id_valid;
  logic [31:0] id_pc, id_instr, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_funct3;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src, id_illegal;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        chk;
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, branch, jump, illegal;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  id_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .stall_in(stall_in), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall_out(stall_out),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_funct3(id_funct3), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_jump(id_jump), .id_alu_src(id_alu_src), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t vld(input logic [31:0] pc, input logic [4:0] rd,
                               input logic [31:0] imm, input logic [31:0] r1,
                               input logic [31:0] r2);
    exp_t x = '0;
    x.chk = 1'b1; x.valid = 1'b1; x.pc = pc; x.rd = rd; x.imm = imm; x.r1 = r1; x.r2 = r2;
    return x;
  endfunction

  task automatic tick(input string tag, input exp_t ex);
    exp_t got;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".valid"},     32'(id_valid),     32'(got.valid));
    chk({tag, ".alu_op"},    32'(id_alu_op),    32'(got.alu_op));
    chk({tag, ".alu_src"},   32'(id_alu_src),   32'(got.alu_src));
    chk({tag, ".reg_write"}, 32'(id_reg_write), 32'(got.reg_write));
    chk({tag, ".mem_read"},  32'(id_mem_read),  32'(got.mem_read));
    chk({tag, ".mem_write"}, 32'(id_mem_write), 32'(got.mem_write));
    chk({tag, ".branch"},    32'(id_branch),    32'(got.branch));
    chk({tag, ".jump"},      32'(id_jump),      32'(got.jump));
    chk({tag, ".illegal"},   32'(id_illegal),   32'(got.illegal));
    if (got.chk) begin
      chk({tag, ".pc"},  id_pc,         got.pc);
      chk({tag, ".rd"},  32'(id_rd),    32'(got.rd));
      chk({tag, ".imm"}, id_imm,        got.imm);
      chk({tag, ".r1"},  id_rs1_data,   got.r1);
      chk({tag, ".r2"},  id_rs2_data,   got.r2);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v; in_pc = pc; in_instr = instr;
  endtask

  task automatic comb(input string tag, input logic expv);
    #1;
    chk(tag, 32'(stall_out), 32'(expv));
  endtask

  initial begin
    rst_ = 1'b1; stall_in = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    ex_mem_read = 1'b0; ex_rd = '0;
    drive(1'b1, 32'h44, 32'h00500093);

    e = '0; e.chk = 1'b1; e.pc = RPC;
    tick("reset0", e);
    tick("reset1", e);

    // addi x1,x0,5
    rst_ = 1'b0;
    drive(1'b1, 32'h10, 32'h00500093);
    e = vld(32'h10, 5'd1, 32'd5, 32'd0, 32'd0); e.alu_src = 1'b1; e.reg_write = 1'b1;
    tick("addi", e);

    // add x3,x1,x0 with same-cycle writeback of x1
    drive(1'b1, 32'h14, 32'h000081B3);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    comb("bypass.stall", 1'b0);
    e = vld(32'h14, 5'd3, 32'd0, 32'hDEADBEEF, 32'd0); e.reg_write = 1'b1;
    tick("bypass", e);

    wb_en = 1'b0;
    drive(1'b1, 32'h18, 32'h000081B3);
    e = vld(32'h18, 5'd3, 32'd0, 32'hDEADBEEF, 32'd0); e.reg_write = 1'b1;
    tick("stored", e);

    // add x3,x2,x1 against a load in EX
    drive(1'b1, 32'h1C, 32'h001101B3);
    ex_mem_read = 1'b1;
    ex_rd = 5'd1; comb("lu.rs2", 1'b1);
    ex_rd = 5'd3; comb("lu.rd_only", 1'b0);
    ex_rd = 5'd0; comb("lu.x0", 1'b0);
    ex_rd = 5'd2; in_valid = 1'b0; comb("lu.invalid", 1'b0);
    in_valid = 1'b1; comb("lu.rs1", 1'b1);
    tick("lu.bubble", '0);
    ex_mem_read = 1'b0;
    comb("lu.release", 1'b0);
    e = vld(32'h1C, 5'd3, 32'd0, 32'd0, 32'hDEADBEEF); e.reg_write = 1'b1;
    tick("lu.issue", e);

    // lui x1 has field bits 19:15 = 8 but does not read rs1
    drive(1'b1, 32'h20, 32'h123450B7);
    ex_mem_read = 1'b1; ex_rd = 5'd8;
    comb("lu.lui", 1'b0);
    ex_mem_read = 1'b0;
    e = vld(32'h20, 5'd1, 32'h12345000, 32'd0, 32'd0);
    e.alu_op = 4'd10; e.alu_src = 1'b1; e.reg_write = 1'b1;
    tick("lui", e);

    // beq x0,x0,-4
    drive(1'b1, 32'h24, 32'hFE000EE3);
    e = vld(32'h24, 5'd29, 32'hFFFFFFFC, 32'd0, 32'd0); e.alu_op = 4'd1; e.branch = 1'b1;
    tick("beq", e);

    // flush beats stall_in and a live load-use hazard
    drive(1'b1, 32'h28, 32'h001101B3);
    flush = 1'b1; stall_in = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd2;
    comb("flush.stall_out", 1'b0);
    tick("flush", '0);
    flush = 1'b0; ex_mem_read = 1'b0;
    drive(1'b1, 32'h2C, 32'h00500093);
    tick("flush.hold", '0);

    stall_in = 1'b0;
    drive(1'b1, 32'h30, 32'h00500093);
    e = vld(32'h30, 5'd1, 32'd5, 32'd0, 32'd0); e.alu_src = 1'b1; e.reg_write = 1'b1;
    tick("addi2", e);
    // stall holds the payload while writeback of x5 still lands
    stall_in = 1'b1;
    drive(1'b1, 32'h34, 32'hFE000EE3);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
    tick("stall.hold", e);
    stall_in = 1'b0; wb_en = 1'b0;
    drive(1'b1, 32'h38, 32'h00028333);
    e = vld(32'h38, 5'd6, 32'd0, 32'h0000_1234, 32'd0); e.reg_write = 1'b1;
    tick("stall.wb", e);

    // illegal opcode while writing 5 to x0
    drive(1'b1, 32'h3C, 32'h0000007F);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd5;
    e = vld(32'h3C, 5'd0, 32'd0, 32'd0, 32'd0); e.illegal = 1'b1;
    tick("illegal", e);
    drive(1'b1, 32'h40, 32'h000001B3);
    e = vld(32'h40, 5'd3, 32'd0, 32'd0, 32'd0); e.reg_write = 1'b1;
    tick("x0.bypass", e);
    wb_en = 1'b0;
    tick("x0.read", e);

    drive(1'b1, 32'h44, 32'h0000000F);
    e = '0; e.valid = 1'b1;
    tick("fence", e);

    // jal x1,8
    drive(1'b1, 32'h48, 32'h008000EF);
    e = vld(32'h48, 5'd1, 32'd8, 32'd0, 32'd0); e.jump = 1'b1; e.reg_write = 1'b1;
    tick("jal", e);

    // sw x2,4(x1)
    drive(1'b1, 32'h4C, 32'h0020A223);
    e = vld(32'h4C, 5'd4, 32'd4, 32'hDEADBEEF, 32'd0); e.mem_write = 1'b1; e.alu_src = 1'b1;
    tick("sw", e);

    // srai x1,x1,3
    drive(1'b1, 32'h50, 32'h4030D093);
    e = vld(32'h50, 5'd1, 32'h0000_0403, 32'hDEADBEEF, 32'd0);
    e.alu_op = 4'd7; e.alu_src = 1'b1; e.reg_write = 1'b1;
    tick("srai", e);
    chk("srai.funct3", 32'(id_funct3), 32'd5);

    // lw x2,-4(x1)
    drive(1'b1, 32'h54, 32'hFFC0A103);
    e = vld(32'h54, 5'd2, 32'hFFFFFFFC, 32'hDEADBEEF, 32'd0);
    e.mem_read = 1'b1; e.alu_src = 1'b1; e.reg_write = 1'b1;
    tick("lw", e);

    drive(1'b0, 32'h58, 32'h00500093);
    tick("idle", '0);

    // reset mid-stream beats flush and stall, and clears the register file
    drive(1'b1, 32'h5C, 32'h00500093);
    rst_ = 1'b1; flush = 1'b1; stall_in = 1'b1;
    e = '0; e.chk = 1'b1; e.pc = RPC;
    tick("rst.mid", e);
    rst_ = 1'b0; flush = 1'b0; stall_in = 1'b0;
    drive(1'b1, 32'h60, 32'h000081B3);
    e = vld(32'h60, 5'd3, 32'd0, 32'd0, 32'd0); e.reg_write = 1'b1;
    tick("rst.rf", e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
